// File: rtl/apb_completer_mem_pkg.sv
// ----------------------------------------------------------------------------
// AXI_to_APB package
// Purpose : shared bus widths, the default memory depth and the APB completer
//           state type used by the APB memory completer and its storage array.
// Ports   : none (package only).
// ----------------------------------------------------------------------------
package AXI_to_APB;

    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int APB_MEM_DEPTH = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/apb_reg_array.sv
// ----------------------------------------------------------------------------
// apb_reg_array
// Purpose : DEPTH x WIDTH word storage with one synchronous write port and one
//           combinational read port. Every word is cleared by reset.
// Ports   : clk      - clock, all updates on the rising edge
//           rst      - synchronous active-high reset, clears every word
//           we_i     - write enable
//           waddr_i  - write word index
//           wdata_i  - write data
//           raddr_i  - read word index
//           rdata_o  - read data (combinational)
// ----------------------------------------------------------------------------
module apb_reg_array #(
    parameter int DEPTH = AXI_to_APB::APB_MEM_DEPTH,
    parameter int WIDTH = AXI_to_APB::DATA_WIDTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage update: reset clears the whole array, otherwise at most one
    // word is written per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_completer_mem.sv
// ----------------------------------------------------------------------------
// apb_completer_mem
// Purpose : APB completer backed by a small word memory. Transfers take
//           WAIT_STATES extra access cycles; misaligned or out-of-range
//           addresses complete with pslverr and are counted in err_count.
// Ports   : clk       - clock, all updates on the rising edge
//           rst       - synchronous active-high reset
//           psel      - requester select
//           penable   - access phase
//           pwrite    - 1 = write, 0 = read
//           paddr     - byte address
//           pwdata    - write data
//           prdata    - read data, non-zero only in a clean read completion
//           pready    - transfer completes this cycle
//           pslverr   - error response, only with pready
//           err_count - saturating count of errored completions
// ----------------------------------------------------------------------------
module apb_completer_mem #(
    parameter int ADDRESS_WIDTH = AXI_to_APB::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = AXI_to_APB::DATA_WIDTH,
    parameter int DEPTH         = AXI_to_APB::APB_MEM_DEPTH,
    parameter int WAIT_STATES   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [ADDRESS_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0]    pwdata,
    output logic [DATA_WIDTH-1:0]    prdata,
    output logic                     pready,
    output logic                     pslverr,
    output logic [7:0]               err_count
);

    import AXI_to_APB::*;

    localparam int IDX_W = $clog2(DEPTH);
    // One extra bit so the byte-size limit cannot overflow the address width.
    localparam logic [ADDRESS_WIDTH:0] ADDR_LIMIT = (ADDRESS_WIDTH+1)'(DEPTH * 4);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    apb_state_e state_q, state_d;
    logic [3:0]               wcnt_q, wcnt_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     write_q, write_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [7:0]               errCnt_q;

    logic                  addrErr;
    logic                  complete;
    logic                  memWe;
    logic [IDX_W-1:0]      memIdx;
    logic [DATA_WIDTH-1:0] memRdata;

    assign memIdx  = addr_q[IDX_W+1:2];
    assign addrErr = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= ADDR_LIMIT);

    // Completion is gated by reset so a transfer caught by reset can never
    // write memory, bump the error count or show a response.
    assign complete = !rst && (state_q == ACCESS) && psel && penable
                      && (wcnt_q == WAIT_LAST);

    assign pready    = complete;
    assign pslverr   = complete && addrErr;
    assign memWe     = complete && write_q && !addrErr;
    assign prdata    = (complete && !write_q && !addrErr) ? memRdata : '0;
    assign err_count = errCnt_q;

    apb_reg_array #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_regs (
        .clk     (clk),
        .rst     (rst),
        .we_i    (memWe),
        .waddr_i (memIdx),
        .wdata_i (wdata_q),
        .raddr_i (memIdx),
        .rdata_o (memRdata)
    );

    // Next-state logic. A setup phase (psel without penable) captures the
    // request both from IDLE and, as a restart, from ACCESS. Dropping psel
    // in ACCESS abandons the transfer silently.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    wcnt_d  = 4'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (!penable) begin
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    wcnt_d  = 4'd0;
                end else if (complete) begin
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers and the saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wcnt_q   <= 4'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            errCnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            if (pslverr && (errCnt_q != 8'hFF)) begin
                errCnt_q <= errCnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_apb_completer_mem.sv
// ----------------------------------------------------------------------------
// tb_apb_completer_mem
// Purpose : self-checking bench for apb_completer_mem. One instance uses one
//           wait state, a second uses none. Expected values come from a
//           word-array model of the memory and a saturating error counter.
// ----------------------------------------------------------------------------
module tb_apb_completer_mem;

    logic clk = 1'b0;
    logic rst;

    // Clock: 10 time-unit period; inputs change and outputs are sampled
    // around the falling edge.
    always #5 clk = ~clk;

    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic [7:0]  errCount;

    logic        psel0, penable0, pwrite0;
    logic [31:0] paddr0, pwdata0, prdata0;
    logic        pready0, pslverr0;
    logic [7:0]  errCount0;

    int checkCount = 0;
    int passCount  = 0;
    int cycleCount = 0;

    logic [31:0] modelMem [16];
    int          modelErrCount;

    apb_completer_mem #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .DEPTH         (16),
        .WAIT_STATES   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .err_count (errCount)
    );

    apb_completer_mem #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .DEPTH         (16),
        .WAIT_STATES   (0)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .psel      (psel0),
        .penable   (penable0),
        .pwrite    (pwrite0),
        .paddr     (paddr0),
        .pwdata    (pwdata0),
        .prdata    (prdata0),
        .pready    (pready0),
        .pslverr   (pslverr0),
        .err_count (errCount0)
    );

    // Free-running cycle counter used to measure transfer spacing.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Hard stop in case some wait is never satisfied.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    function automatic logic modelIsErr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'd64);
    endfunction

    task automatic idleCycles(input int n);
        psel    = 1'b0;
        penable = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // One complete transfer on the one-wait-state instance, starting at a
    // falling edge and returning at the falling edge after completion.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic scramble,
                                 output logic [31:0] rdataSeen, output logic errSeen,
                                 output int waitCycles);
        logic done;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(negedge clk);
        penable = 1'b1;
        if (scramble) begin
            paddr  = $urandom;
            pwdata = $urandom;
        end
        waitCycles = 0;
        rdataSeen  = '0;
        errSeen    = 1'b0;
        done       = 1'b0;
        while (!done) begin
            #1;
            waitCycles++;
            if (pready) begin
                rdataSeen = prdata;
                errSeen   = pslverr;
                done      = 1'b1;
            end else if (waitCycles >= 20) begin
                checkOutput("pready_timeout", pready, 1'b1);
                done = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    // Transfer plus comparison against the memory/error model.
    task automatic doTransfer(input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic scramble,
                              input string tag);
        logic [31:0] rd;
        logic        er;
        int          wc;
        logic        expErr;
        logic [31:0] expRd;
        expErr = modelIsErr(addr);
        expRd  = (!wr && !expErr) ? modelMem[addr[5:2]] : 32'h0;
        applyStimulus(wr, addr, data, scramble, rd, er, wc);
        checkOutput({tag, "_prdata"}, rd, expRd);
        checkOutput({tag, "_pslverr"}, er, expErr);
        checkOutput({tag, "_penable_cycles"}, wc, 2);
        if (wr && !expErr) modelMem[addr[5:2]] = data;
        if (expErr && modelErrCount < 255) modelErrCount++;
        checkOutput({tag, "_err_count"}, errCount, modelErrCount);
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) modelMem[i] = 32'h0;
        modelErrCount = 0;
    endtask

    initial begin
        int t0, t1, t2;
        logic [31:0] a;
        logic        w;
        rst = 1'b1;
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        psel0 = 0; penable0 = 0; pwrite0 = 0; paddr0 = 0; pwdata0 = 0;
        modelReset();
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_pready", pready, 1'b0);
        checkOutput("rst_pslverr", pslverr, 1'b0);
        checkOutput("rst_prdata", prdata, 32'h0);
        checkOutput("rst_err_count", errCount, 8'd0);
        checkOutput("rst_pready_ws0", pready0, 1'b0);
        rst = 1'b0;
        idleCycles(1);

        $display("[TB] zero wait-state instance");
        psel0 = 1; penable0 = 0; pwrite0 = 1; paddr0 = 32'hC; pwdata0 = 32'hCAFE_F00D;
        @(negedge clk);
        penable0 = 1;
        #1 checkOutput("ws0_wr_pready", pready0, 1'b1);
        checkOutput("ws0_wr_pslverr", pslverr0, 1'b0);
        @(negedge clk);
        penable0 = 0; pwrite0 = 0;
        @(negedge clk);
        penable0 = 1;
        #1 checkOutput("ws0_rd_pready", pready0, 1'b1);
        checkOutput("ws0_rd_prdata", prdata0, 32'hCAFE_F00D);
        @(negedge clk);
        psel0 = 0; penable0 = 0;
        @(negedge clk);
        psel0 = 1; penable0 = 1;
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput("ws0_no_setup_pready", pready0, 1'b0);
            @(negedge clk);
        end
        psel0 = 0; penable0 = 0;

        $display("[TB] basic write/read");
        doTransfer(1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0, "wr8");
        idleCycles(1);
        doTransfer(1'b0, 32'h8, 32'h0, 1'b0, "rd8");
        idleCycles(1);

        $display("[TB] error responses");
        doTransfer(1'b0, 32'h40, 32'h0, 1'b0, "rd40_err");
        doTransfer(1'b1, 32'h6, 32'h1234_5678, 1'b0, "wr6_err");
        doTransfer(1'b0, 32'h4, 32'h0, 1'b0, "rd4_after_err");
        idleCycles(1);

        $display("[TB] back-to-back");
        t0 = cycleCount;
        doTransfer(1'b1, 32'h0, 32'h1111_1111, 1'b0, "b2b_wr");
        t1 = cycleCount;
        doTransfer(1'b0, 32'h0, 32'h0, 1'b0, "b2b_rd");
        t2 = cycleCount;
        checkOutput("b2b_period_1", t1 - t0, 3);
        checkOutput("b2b_period_2", t2 - t1, 3);
        idleCycles(1);

        $display("[TB] abort");
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h4; pwdata = 32'hAAAA_AAAA;
        @(negedge clk);
        penable = 1;
        #1 checkOutput("abort_pready_1", pready, 1'b0);
        @(negedge clk);
        psel = 0; penable = 0;
        #1 checkOutput("abort_pready_2", pready, 1'b0);
        @(negedge clk);
        doTransfer(1'b0, 32'h4, 32'h0, 1'b0, "abort_rd4");
        idleCycles(1);

        $display("[TB] restarted setup");
        psel = 1; penable = 0; pwrite = 1; paddr = 32'hC; pwdata = 32'h55;
        @(negedge clk);
        paddr = 32'h14; pwdata = 32'h77;
        @(negedge clk);
        penable = 1;
        #1 checkOutput("restart_pready_1", pready, 1'b0);
        @(negedge clk);
        #1 checkOutput("restart_pready_2", pready, 1'b1);
        checkOutput("restart_pslverr", pslverr, 1'b0);
        @(negedge clk);
        modelMem[5] = 32'h77;
        doTransfer(1'b0, 32'h14, 32'h0, 1'b0, "restart_rd14");
        doTransfer(1'b0, 32'hC, 32'h0, 1'b0, "restart_rdC");
        idleCycles(1);

        $display("[TB] randomized transfers");
        for (int n = 0; n < 40; n++) begin
            w = 1'(($urandom_range(0, 1)));
            case ($urandom_range(0, 3))
                0: a = ($urandom | 32'h40) & 32'hFFFF_FFFC;
                1: a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
                default: a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            endcase
            doTransfer(w, a, $urandom, 1'($urandom_range(0, 1)), "rand");
            if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 2));
        end
        idleCycles(1);

        $display("[TB] error counter saturation");
        for (int n = 0; n < 256; n++) begin
            doTransfer(1'b0, 32'h40, 32'h0, 1'b0, "sat");
        end
        checkOutput("sat_err_count", errCount, 8'd255);
        doTransfer(1'b0, 32'h41, 32'h0, 1'b0, "sat_hold");
        checkOutput("sat_hold_err_count", errCount, 8'd255);

        rst = 1'b1;
        psel = 0; penable = 0;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        checkOutput("post_rst_err_count", errCount, 8'd0);
        for (int i = 0; i < 16; i++) begin
            doTransfer(1'b0, 32'(i * 4), 32'h0, 1'b0, "post_rst_rd");
        end
        idleCycles(1);

        $display("[TB] reset mid-transfer");
        doTransfer(1'b1, 32'h8, 32'h0BAD_F00D, 1'b0, "pre_mid_rst_wr");
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h3; pwdata = 32'h1234_5678;
        @(negedge clk);
        penable = 1;
        #1 checkOutput("mid_rst_pready_1", pready, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("mid_rst_pready_2", pready, 1'b0);
        checkOutput("mid_rst_pslverr", pslverr, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        doTransfer(1'b0, 32'h8, 32'h0, 1'b0, "after_mid_rst_rd8");
        idleCycles(1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
